// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding load/store responder in front of on-chip data RAM.
// Define DMEM_MISALIGN_ERR_EN to flag misaligned word/halfword requests through rsp_err.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} stateT;

  stateT       state, nextState;
  logic [3:0]  waitCnt, nextWaitCnt;
  logic [31:0] mem [DEPTH_WORDS];

  logic          latWe;
  logic [AW+1:0] latAddr;
  logic [3:0]    latBe;
  logic [31:0]   latWdata;

  logic          accept, enterResp, rspHandshake, misaligned, ramWe;
  logic          curWe;
  logic [AW+1:0] curAddr;
  logic [AW-1:0] curIdx;
  logic [3:0]    curBe;
  logic [31:0]   curWdata;
  logic          rspValidReg, rspErrReg;
  logic [31:0]   rspRdataReg;
  logic          unusedAddrBits;

  assign req_ready    = rst && (state == IDLE);
  assign accept       = req_valid && req_ready;
  assign rspHandshake = (state == RESP) && rsp_ready;
  assign busy         = (state != IDLE);
  assign rsp_valid    = rspValidReg;
  assign rsp_rdata    = rspRdataReg;
  assign rsp_err      = rspErrReg;

  assign unusedAddrBits = ^{req_addr[31:AW+2], latAddr[1:0], req_addr[1:0]};

  // With zero wait states the RESP entry edge is the accept edge, so the live request is used.
  always_comb begin
    curWe    = latWe;
    curAddr  = latAddr;
    curBe    = latBe;
    curWdata = latWdata;
    if (state == IDLE) begin
      curWe    = req_we;
      curAddr  = req_addr[AW+1:0];
      curBe    = req_be;
      curWdata = req_wdata;
    end
  end

  assign curIdx = curAddr[AW+1:2];

  always_comb begin
`ifdef DMEM_MISALIGN_ERR_EN
    misaligned = ((curBe == 4'b1111) && (curAddr[1:0] != 2'b00)) ||
                 (((curBe == 4'b0011) || (curBe == 4'b1100)) && curAddr[0]);
`else
    misaligned = 1'b0;
`endif
  end

  always_comb begin
    nextState   = state;
    nextWaitCnt = waitCnt;
    enterResp   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            nextState = RESP;
            enterResp = 1'b1;
          end else begin
            nextState   = WAIT;
            nextWaitCnt = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        if (waitCnt == 4'd0) begin
          nextState = RESP;
          enterResp = 1'b1;
        end else begin
          nextWaitCnt = waitCnt - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      waitCnt     <= 4'd0;
      latWe       <= 1'b0;
      latAddr     <= '0;
      latBe       <= 4'd0;
      latWdata    <= 32'd0;
      rspValidReg <= 1'b0;
      rspRdataReg <= 32'd0;
      rspErrReg   <= 1'b0;
    end else begin
      state   <= nextState;
      waitCnt <= nextWaitCnt;
      if (accept) begin
        latWe    <= req_we;
        latAddr  <= req_addr[AW+1:0];
        latBe    <= req_be;
        latWdata <= req_wdata;
      end
      if (enterResp) begin
        rspValidReg <= 1'b1;
        rspRdataReg <= (curWe || misaligned) ? 32'd0 : mem[curIdx];
        rspErrReg   <= misaligned;
      end else if (rspHandshake) begin
        rspValidReg <= 1'b0;
        rspRdataReg <= 32'd0;
        rspErrReg   <= 1'b0;
      end
    end
  end

  // RAM is never reset; a reset abort forces IDLE, which keeps ramWe low.
  assign ramWe = enterResp && curWe && !misaligned;

  always_ff @(posedge clk) begin
    if (ramWe) begin
      for (int i = 0; i < 4; i++) begin
        if (curBe[i]) mem[curIdx][8*i +: 8] <= curWdata[8*i +: 8];
      end
    end
  end

endmodule
